trg_id_tx: RTL and testbench

- Sits directly downstream of the trigger output controller and consumes its one-clock effective-trigger pulse.
- Maintains the 16-bit effective-trigger counter (trigger ID) that is fed back to the controller's trigger-ID input.
- After each accepted trigger, transmits that trigger ID as an active-low serial frame to the front-end electronics, so each FEE can tag its event.
- System clock is 50 MHz.

---
 rtl/trg_pkg.sv | 22 ++
 rtl/trg_id_bit_timer.sv | 26 ++
 rtl/trg_id_tx.sv | 129 ++++++++++++
 tb/tb_trg_id_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pkg.sv
// Shared definitions for the trigger-ID transmitter: frame state encoding,
// default widths/timings and derived frame length.
package trg_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int BIT_PERIOD_DEF = 10;
  localparam int GAP_CYCLES_DEF = 25;

  // start + 16 data + parity + stop
  localparam int FRAME_BITS     = 19;
  localparam int FRAME_CYCLES   = GAP_CYCLES_DEF + FRAME_BITS * BIT_PERIOD_DEF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GAP    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tid_state_t;

endpackage

// File: rtl/trg_id_bit_timer.sv
// Bit-period prescaler: counts 0..BIT_PERIOD-1 and ticks on terminal count.
// clr_in restarts the period so every frame state gets a full bit time.
module trg_id_bit_timer #(
  parameter int BIT_PERIOD = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  output logic tick_out
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [TW-1:0] cnt;

  assign tick_out = (cnt == TW'(BIT_PERIOD - 1));

  // free-running period counter, restarted on clear and at terminal count
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        cnt <= '0;
    else if (clr_in)   cnt <= '0;
    else if (tick_out) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/trg_id_tx.sv
// Trigger-ID counter and serial transmitter. Counts effective triggers and,
// after each accepted trigger, sends the new ID as an active-low frame:
// gap, start, 16 data bits MSB first, even parity, stop.
// No handshake: eff_trg_in is a bare one-clock strobe; a strobe that arrives
// while a frame is pending is counted but not sent, and flags overrun.
module trg_id_tx
  import trg_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int BIT_PERIOD = BIT_PERIOD_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             eff_trg_in,
  input  logic             cnt_clr_in,
  input  logic             tid_enb_in,
  input  logic             ovr_clr_in,
  output logic [CNT_W-1:0] eff_trg_cnt_out,
  output logic             tid_ser_N_out,
  output logic             tid_busy_out,
  output logic             tid_ovr_out
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tid_state_t       state;
  tid_state_t       state_next;
  logic [GW-1:0]    gap_cnt;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] shreg;
  logic [CNT_W-1:0] shreg_next;
  logic [CNT_W-1:0] trg_id_next;
  logic             par;
  logic             tick;
  logic             accept;
  logic             ovr_set;
  logic             line_next;

  assign trg_id_next  = eff_trg_cnt_out + CNT_W'(1);
  assign accept       = eff_trg_in && (state == IDLE) && tid_enb_in && !cnt_clr_in;
  assign ovr_set      = eff_trg_in && !cnt_clr_in && (state != IDLE);
  assign tid_busy_out = (state != IDLE);

  trg_id_bit_timer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_in   (state_next != state),
    .tick_out (tick)
  );

  // trigger ID counter; clear beats increment
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)          eff_trg_cnt_out <= '0;
    else if (cnt_clr_in) eff_trg_cnt_out <= '0;
    else if (eff_trg_in) eff_trg_cnt_out <= trg_id_next;
  end

  // sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)          tid_ovr_out <= 1'b0;
    else if (ovr_set)    tid_ovr_out <= 1'b1;
    else if (ovr_clr_in) tid_ovr_out <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = GAP;
      GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_idx == 4'(CNT_W - 1))) state_next = PARITY;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // shift register next value: load on accept, shift at end of each data bit
  always_comb begin
    shreg_next = shreg;
    if (accept)                       shreg_next = trg_id_next;
    else if ((state == DATA) && tick) shreg_next = {shreg[CNT_W-2:0], 1'b0};
  end

  // FSM output: line level for the upcoming cycle, from next state/data
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = ~shreg_next[CNT_W-1];
      PARITY:  line_next = ~par;
      default: line_next = 1'b1;
    endcase
  end

  // frame datapath: gap counter, bit index, latched ID and parity
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gap_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      shreg <= shreg_next;
      if (accept) par <= ^trg_id_next;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
      if (state != DATA) bit_idx <= '0;
      else if (tick)     bit_idx <= bit_idx + 1'b1;
    end
  end

  // registered serial line so it never glitches
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) tid_ser_N_out <= 1'b1;
    else        tid_ser_N_out <= line_next;
  end

endmodule

// File: tb/tb_trg_id_tx.sv
// Directed bench for trg_id_tx: reset, counter vector table, full frames
// checked cycle by cycle against a frame model, overrun, mid-frame enable
// drop and counter clear, counter wrap, and asynchronous reset mid-frame.
module tb_trg_id_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        eff_trg;
  logic        cnt_clr;
  logic        tid_enb;
  logic        ovr_clr;
  logic [15:0] cnt;
  logic        ser_n;
  logic        busy;
  logic        ovr;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt;

  typedef struct {
    logic        trg;
    logic        clr;
    logic        enb;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[6];

  trg_id_tx dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .eff_trg_in      (eff_trg),
    .cnt_clr_in      (cnt_clr),
    .tid_enb_in      (tid_enb),
    .ovr_clr_in      (ovr_clr),
    .eff_trg_cnt_out (cnt),
    .tid_ser_N_out   (ser_n),
    .tid_busy_out    (busy),
    .tid_ovr_out     (ovr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected line level k clocks after the accepting edge
  function automatic logic exp_line(input int k, input logic [15:0] d);
    if (k < 25)  return 1'b1;
    if (k < 35)  return 1'b0;
    if (k < 195) return ~d[15 - (k - 35) / 10];
    if (k < 205) return ~(^d);
    return 1'b1;
  endfunction

  // one-cycle trigger that is expected to count
  task automatic pulse_trg();
    eff_trg = 1'b1;
    @(negedge clk);
    eff_trg = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("cnt_after_trg", {16'd0, cnt}, {16'd0, exp_cnt});
  endtask

  // hold trigger high n cycles with transmission disabled
  task automatic hold_trg(input int n);
    int bad = 0;
    eff_trg = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ser_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    eff_trg = 1'b0;
    exp_cnt = exp_cnt + 16'(n);
    chk("line_idle_during_burst", bad, 0);
  endtask

  // check line/busy for k = 0..stop_at-1 after acceptance; mode injects
  // 1: overrun triggers, 2: enable drop and counter clear mid-frame
  task automatic run_frame(input logic [15:0] d, input int mode, input int stop_at);
    for (int k = 0; k < stop_at; k++) begin
      chk("frame_line", {31'd0, ser_n}, {31'd0, exp_line(k, d)});
      chk("frame_busy", {31'd0, busy}, {31'd0, (k < 215)});
      if (mode == 1) begin
        if (k == 50) eff_trg = 1'b1;
        if (k == 51) begin
          eff_trg = 1'b0;
          exp_cnt = exp_cnt + 16'd1;
          chk("ovr_cnt", {16'd0, cnt}, {16'd0, exp_cnt});
          chk("ovr_set", {31'd0, ovr}, 32'd1);
        end
        if (k == 60) begin
          eff_trg = 1'b1;
          ovr_clr = 1'b1;
        end
        if (k == 61) begin
          eff_trg = 1'b0;
          ovr_clr = 1'b0;
          exp_cnt = exp_cnt + 16'd1;
          chk("ovr_cnt2", {16'd0, cnt}, {16'd0, exp_cnt});
          chk("ovr_set_beats_clr", {31'd0, ovr}, 32'd1);
        end
      end
      if (mode == 2) begin
        if (k == 40) tid_enb = 1'b0;
        if (k == 70) cnt_clr = 1'b1;
        if (k == 71) begin
          cnt_clr = 1'b0;
          exp_cnt = 16'd0;
          chk("midframe_clr_cnt", {16'd0, cnt}, 32'd0);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input string nm, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ser_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    vecs[0] = '{trg: 1'b1, clr: 1'b0, enb: 1'b0, cnt: 16'h0004};
    vecs[1] = '{trg: 1'b1, clr: 1'b0, enb: 1'b0, cnt: 16'h0005};
    vecs[2] = '{trg: 1'b1, clr: 1'b1, enb: 1'b1, cnt: 16'h0000};
    vecs[3] = '{trg: 1'b0, clr: 1'b1, enb: 1'b0, cnt: 16'h0000};
    vecs[4] = '{trg: 1'b1, clr: 1'b0, enb: 1'b0, cnt: 16'h0001};
    vecs[5] = '{trg: 1'b0, clr: 1'b0, enb: 1'b0, cnt: 16'h0001};

    // reset
    rst = 1'b1; eff_trg = 1'b0; cnt_clr = 1'b0; tid_enb = 1'b0; ovr_clr = 1'b0;
    exp_cnt = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cnt",  {16'd0, cnt},   32'd0);
    chk("rst_line", {31'd0, ser_n}, 32'd1);
    chk("rst_busy", {31'd0, busy},  32'd0);
    chk("rst_ovr",  {31'd0, ovr},   32'd0);
    @(negedge clk);

    // frame 0x0001 with overrun triggers injected
    tid_enb = 1'b1;
    pulse_trg();
    chk("first_id", {16'd0, cnt}, 32'h0001);
    run_frame(16'h0001, 1, 216);
    idle_check("no_second_frame", 300);
    chk("ovr_sticky", {31'd0, ovr}, 32'd1);
    chk("cnt_after_ovr", {16'd0, cnt}, 32'h0003);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_cleared", {31'd0, ovr}, 32'd0);

    // counter vector table, incl. clear+trigger with enable at cnt 5
    tid_enb = 1'b0;
    foreach (vecs[i]) begin
      eff_trg = vecs[i].trg;
      cnt_clr = vecs[i].clr;
      tid_enb = vecs[i].enb;
      @(negedge clk);
      eff_trg = 1'b0; cnt_clr = 1'b0; tid_enb = 1'b0;
      chk("vec_cnt",  {16'd0, cnt},   {16'd0, vecs[i].cnt});
      chk("vec_busy", {31'd0, busy},  32'd0);
      chk("vec_line", {31'd0, ser_n}, 32'd1);
      chk("vec_ovr",  {31'd0, ovr},   32'd0);
      exp_cnt = vecs[i].cnt;
    end
    idle_check("idle_after_table", 40);

    // enable dropped and counter cleared mid-frame: frame 0x00A5 completes
    hold_trg(16'hA4 - exp_cnt);
    chk("cnt_a4", {16'd0, cnt}, 32'h00A4);
    tid_enb = 1'b1;
    pulse_trg();
    run_frame(16'h00A5, 2, 216);
    chk("cnt_kept_clear", {16'd0, cnt}, 32'd0);
    pulse_trg();
    chk("disabled_no_busy", {31'd0, busy}, 32'd0);
    idle_check("disabled_no_frame", 40);

    // wrap: 65535 triggers disabled, then enabled trigger sends 0x0000
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cnt = 16'd0;
    chk("cnt_clr", {16'd0, cnt}, 32'd0);
    hold_trg(65535);
    chk("cnt_full", {16'd0, cnt}, 32'hFFFF);
    tid_enb = 1'b1;
    pulse_trg();
    chk("cnt_wrap", {16'd0, cnt}, 32'h0000);
    run_frame(16'h0000, 0, 216);

    // asynchronous reset during the start bit
    pulse_trg();
    run_frame(16'h0001, 0, 31);
    chk("pre_rst_line_low", {31'd0, ser_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", {31'd0, ser_n}, 32'd1);
    chk("async_rst_busy", {31'd0, busy},  32'd0);
    chk("async_rst_cnt",  {16'd0, cnt},   32'd0);
    chk("async_rst_ovr",  {31'd0, ovr},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    tid_enb = 1'b0;
    exp_cnt = 16'd0;
    idle_check("idle_after_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
